// File: rtl/syzygy_adc_capture.sv
// rtl/syzygy_adc_capture.sv - triggered dual-channel ADC sample capture into a downstream FIFO
//
// Ports:
//   clk, reset            ADC data clock; synchronous active-high reset
//   adc_data_1/2          channel samples (offset binary); data_valid & rdy marks a usable pair
//   arm, abort            single-cycle start / cancel requests
//   trig_mode, trig_level trigger selection (0 immediate, 1 rising crossing on ch1), latched at arm
//   capture_len           number of sample slots per capture, latched at arm
//   fifo_full             downstream back-pressure; a slot hit while full is dropped and counted
//   fifo_wr_en, fifo_din  registered write strobe and {ch2, ch1} data
//   busy, done            ARMED/CAPTURE and DONE decodes of the state register
//   overflow              sticky drop flag for the current capture
//   sample_count          slots consumed in the current capture

module syzygy_adc_capture #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          adc_data_1,
  input  logic [15:0]          adc_data_2,
  input  logic                 data_valid,
  input  logic                 rdy,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_mode,
  input  logic [15:0]          trig_level,
  input  logic [LEN_WIDTH-1:0] capture_len,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [31:0]          fifo_din,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_WIDTH-1:0] sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [15:0]          level_q, level_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [15:0]          prev_q, prev_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 wr_en_q, wr_en_d;
  logic [31:0]          din_q, din_d;

  logic                 sample_ok;
  logic                 trig_hit;
  logic                 slot;
  logic [LEN_WIDTH-1:0] count_inc;

  assign sample_ok = data_valid & rdy;
  // Slots are only taken while count_q < len_q, so this increment cannot wrap.
  assign count_inc = count_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    level_d    = level_q;
    len_d      = len_q;
    prev_d     = prev_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    trig_hit   = 1'b0;
    slot       = 1'b0;

    if (abort) begin
      // Abort beats everything else on this edge, including a pending slot.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            mode_d     = trig_mode;
            level_d    = trig_level;
            len_d      = capture_len;
            count_d    = '0;
            overflow_d = 1'b0;
            // All-ones history means the first sample after arm can never
            // satisfy prev < level, so a level trigger needs a real crossing.
            prev_d     = 16'hFFFF;
            state_d    = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (len_q == '0) begin
            state_d = ST_DONE;
          end else if (sample_ok) begin
            prev_d   = adc_data_1;
            trig_hit = !mode_q || ((prev_q < level_q) && (adc_data_1 >= level_q));
            slot     = trig_hit;
          end
        end
        ST_CAPTURE: begin
          slot = sample_ok;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (slot) begin
        count_d = count_inc;
        if (fifo_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          din_d   = {adc_data_2, adc_data_1};
        end
        state_d = (count_inc == len_q) ? ST_DONE : ST_CAPTURE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      level_q    <= 16'h0000;
      len_q      <= '0;
      prev_q     <= 16'hFFFF;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      din_q      <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      len_q      <= len_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_din     = din_q;
  assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);
  assign overflow     = overflow_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// tb/tb_syzygy_adc_capture.sv - scoreboard bench for syzygy_adc_capture

module tb_syzygy_adc_capture;

  localparam int LW = 16;

  logic          clk;
  logic          reset;
  logic [15:0]   adc_data_1, adc_data_2;
  logic          data_valid, rdy, arm, abort, trig_mode, fifo_full;
  logic [15:0]   trig_level;
  logic [LW-1:0] capture_len;
  logic          fifo_wr_en, busy, done, overflow;
  logic [31:0]   fifo_din;
  logic [LW-1:0] sample_count;

  syzygy_adc_capture #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .adc_data_1(adc_data_1), .adc_data_2(adc_data_2),
    .data_valid(data_valid), .rdy(rdy), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .capture_len(capture_len),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy), .done(done), .overflow(overflow), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the capture rules applied once per clock edge.
  typedef enum {P_IDLE, P_ARMED, P_CAPT, P_DONE} phase_t;
  typedef struct {logic [31:0] din; int at;} wexp_t;

  phase_t      m_ph = P_IDLE;
  bit          m_mode;
  logic [15:0] m_level;
  logic [15:0] m_prev = 16'hFFFF;
  int          m_len, m_taken;
  bit          m_ovf, m_wr;
  logic [31:0] m_din;
  int          cyc = 0;
  wexp_t       sb[$];
  logic [31:0] wr_log[$];

  task automatic take_slot();
    wexp_t e;
    m_taken++;
    if (fifo_full) m_ovf = 1;
    else begin
      m_wr   = 1;
      m_din  = {adc_data_2, adc_data_1};
      e.din  = m_din;
      e.at   = cyc;
      sb.push_back(e);
    end
    m_ph = (m_taken == m_len) ? P_DONE : P_CAPT;
  endtask

  always @(posedge clk) begin
    bit valid;
    cyc++;
    m_wr = 0;
    valid = data_valid && rdy;
    if (reset) begin
      m_ph = P_IDLE; m_mode = 0; m_level = 0; m_len = 0; m_taken = 0;
      m_prev = 16'hFFFF; m_ovf = 0; m_din = 0;
      sb.delete();
    end else if (abort) begin
      m_ph = P_IDLE;
    end else if ((m_ph == P_IDLE || m_ph == P_DONE) && arm) begin
      m_mode = trig_mode; m_level = trig_level; m_len = int'(capture_len);
      m_taken = 0; m_ovf = 0; m_prev = 16'hFFFF; m_ph = P_ARMED;
    end else if (m_ph == P_ARMED && m_len == 0) begin
      m_ph = P_DONE;
    end else if (m_ph == P_ARMED && valid) begin
      bit hit;
      hit = !m_mode || (m_prev < m_level && adc_data_1 >= m_level);
      m_prev = adc_data_1;
      if (hit) take_slot();
    end else if (m_ph == P_CAPT && valid) begin
      take_slot();
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    wexp_t e;
    check("wr_en", {31'd0, fifo_wr_en}, {31'd0, m_wr});
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_din);
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: got din %h expected no write", fifo_din);
      end else begin
        e = sb.pop_front();
        check("write_din", fifo_din, e.din);
        check("write_cycle", cyc, e.at);
      end
    end else begin
      sb.delete();
    end
    check("fifo_din", fifo_din, m_din);
    check("busy", {31'd0, busy}, {31'd0, (m_ph == P_ARMED || m_ph == P_CAPT)});
    check("done", {31'd0, done}, {31'd0, (m_ph == P_DONE)});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("sample_count", {16'd0, sample_count}, m_taken);
  end

  task automatic step(input bit dv, input bit r, input bit a, input bit ab, input bit full,
                      input logic [15:0] d1, input logic [15:0] d2);
    data_valid = dv; rdy = r; arm = a; abort = ab; fifo_full = full;
    adc_data_1 = d1; adc_data_2 = d2;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic start(input bit mode, input logic [15:0] lvl, input int len);
    trig_mode = mode; trig_level = lvl; capture_len = LW'(len);
    step(0, 1, 1, 0, 0, 16'h0, 16'h0);
    wr_log.delete();
  endtask

  initial begin
    reset = 1; data_valid = 0; rdy = 0; arm = 0; abort = 0; fifo_full = 0;
    adc_data_1 = 0; adc_data_2 = 0; trig_mode = 0; trig_level = 0; capture_len = 0;
    step(0, 0, 0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0, 16'h0);
    check("reset_din", fifo_din, 32'h0);
    check("reset_busy_done", {30'd0, busy, done}, 32'h0);
    reset = 0;
    idle(2);

    // Immediate trigger, ramp on channel 1.
    start(0, 16'h0, 4);
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 0, 16'h0100 + 16'(k), 16'($urandom));
    check("ramp_writes", wr_log.size(), 4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++)
      check("ramp_ch1", {16'd0, wr_log[k][15:0]}, 32'h0100 + k);
    check("ramp_done", {31'd0, done}, 32'd1);
    check("ramp_count", {16'd0, sample_count}, 32'd4);
    check("ramp_ovf", {31'd0, overflow}, 32'd0);
    idle(2);

    // Level trigger; the first 0x9000 right after arm must not fire.
    begin
      logic [15:0] seq [5];
      seq = '{16'h9000, 16'h7000, 16'h7FFF, 16'h8000, 16'h9000};
      start(1, 16'h8000, 2);
      for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, seq[k], 16'h1234);
      idle(2);
      check("lvl_writes", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
        check("lvl_first", {16'd0, wr_log[0][15:0]}, 32'h8000);
        check("lvl_second", {16'd0, wr_log[1][15:0]}, 32'h9000);
      end
    end

    // Back-pressure on slots 3 and 4.
    start(0, 16'h0, 8);
    for (int k = 1; k <= 10; k++) step(1, 1, 0, 0, (k == 3 || k == 4), 16'(k), 16'(k * 3));
    check("bp_writes", wr_log.size(), 6);
    check("bp_ovf", {31'd0, overflow}, 32'd1);
    check("bp_count", {16'd0, sample_count}, 32'd8);
    check("bp_done", {31'd0, done}, 32'd1);

    // Sparse valid with a rdy-low window.
    start(0, 16'h0, 5);
    for (int c = 0; c < 40; c++) step((c % 4) == 0, !(c >= 10 && c < 20), 0, 0, 0, 16'(c), 16'hBEEF);
    check("sparse_writes", wr_log.size(), 5);
    for (int k = 0; k < 5 && k < wr_log.size(); k++)
      check("sparse_ch1", {16'd0, wr_log[k][15:0]}, (k < 3) ? 32'(k * 4) : 32'(20 + (k - 3) * 4));

    // Abort with a simultaneous valid sample and arm.
    start(0, 16'h0, 10);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 16'(k), 16'h0);
    step(1, 1, 1, 1, 0, 16'hAAAA, 16'h5555);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {16'd0, sample_count}, 32'd3);
    idle(1);
    check("abort_arm_ignored", {31'd0, busy}, 32'd0);
    check("abort_writes", wr_log.size(), 3);
    start(0, 16'h0, 0);
    step(1, 1, 0, 0, 0, 16'h1, 16'h1);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_writes", wr_log.size(), 0);

    // Reset in the middle of a capture, then a clean capture.
    start(0, 16'h0, 6);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 16'(k), 16'h0);
    reset = 1;
    step(1, 1, 1, 1, 0, 16'h7777, 16'h7777);
    reset = 0;
    check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_din", fifo_din, 32'h0);
    check("rst_count", {16'd0, sample_count}, 32'd0);
    start(0, 16'h0, 3);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 16'h40 + 16'(k), 16'h0);
    check("clean_writes", wr_log.size(), 3);
    check("clean_done", {31'd0, done}, 32'd1);

    // Randomized traffic; the monitor checks every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      trig_mode   = 1'($urandom);
      trig_level  = 16'($urandom);
      capture_len = LW'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9, $urandom_range(0, 14) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
           16'($urandom), 16'($urandom));
    end
    reset = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
